i2c_bus_cond: RTL and testbench
===============================

# i2c_bus_cond

Input conditioner for the single-byte I2C slave. It synchronises the raw SCL/SDA pins into the `i_clk` domain and rejects glitches. It then emits clean levels, single-cycle SCL edge strobes and START/STOP strobes, plus a bus-busy flag that honours tBUF. It sits between the pad inputs and the slave's `i_scl`/`i_sda`, so the slave never sees metastable or spiky inputs.

## Interface
Parameters:
- `FILT_CLKS`, default 3: consecutive cycles a synced line must differ from its filtered level before the filtered level flips. Legal range 1..(2^`FILT_WIDTH`)-1.
- `FILT_WIDTH`, default 2: width of each filter counter.
- `BUS_FREE_CLKS`, default 80: tBUF, in clocks, after STOP before `o_busy` drops.
- `BUS_IDLE_CLKS`, default 800: cycles with both lines high that force `o_busy` low (stuck-master recovery).
- `IDLE_WIDTH`, default 10: width of the shared busy/idle counter. Must hold max(`BUS_FREE_CLKS`, `BUS_IDLE_CLKS`).

Ports:
- `i_clk`  in  1  single clock.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_scl`  in  1  raw SCL pin, asynchronous.
- `i_sda`  in  1  raw SDA pin, asynchronous.
- `o_scl`  out  1  filtered SCL level.
- `o_sda`  out  1  filtered SDA level.
- `o_scl_rise`  out  1  one-cycle strobe, filtered SCL 0->1.
- `o_scl_fall`  out  1  one-cycle strobe, filtered SCL 1->0.
- `o_start`  out  1  one-cycle strobe, START or repeated START.
- `o_stop`  out  1  one-cycle strobe, STOP.
- `o_busy`  out  1  bus owned by some master.

## Operation
- Sync: each line passes through a 2-FF synchroniser. Both flops reset to 1.
- Filter (per line): counter `cnt` compares the synced value `s` with the filtered level `f`.
  - If `s == f`: `cnt` <= 0.
  - Else if `cnt == FILT_CLKS-1`: `f` <= `s` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Result: any pulse shorter than `FILT_CLKS` cycles (post-sync) is dropped entirely.
- Edge strobes are registered. Each is high in the same cycle the new filtered level first appears on `o_scl`.
- `o_start`: filtered SDA 1->0 while filtered SCL is 1 both before and after that update.
- `o_stop`: filtered SDA 1->0 reversed, i.e. SDA 0->1, with the same SCL condition.
- If SCL and SDA flip in the same cycle, neither `o_start` nor `o_stop` fires. The edge strobe still fires.
- Busy FSM, states IDLE, BUSY, TBUF. One down-counter is shared.
  - IDLE -> BUSY on `o_start`.
  - BUSY -> TBUF on `o_stop`; counter loaded with `BUS_FREE_CLKS`.
  - TBUF -> IDLE when the counter reaches 0.
  - TBUF -> BUSY on `o_start`: counter abandoned, START honoured.
  - BUSY: counter loaded with `BUS_IDLE_CLKS` whenever either filtered line is 0, decremented while both are 1, and BUSY -> IDLE at 0.
  - `o_busy` is 1 in BUSY and TBUF.
- In IDLE, `o_start` is the only way to become busy. A lone SCL fall without START leaves `o_busy` at 0.

## Timing
- Reset values: `o_scl`=1, `o_sda`=1, all strobes 0, `o_busy`=0, FSM in IDLE, all counters 0. Reset asserted mid-transfer forces these immediately, asynchronously.
- Pin-to-level latency: 2 sync cycles + `FILT_CLKS` cycles. Defaults give 5 clocks.
- Strobes are exactly one cycle wide. Back-to-back strobes are possible only with `FILT_CLKS`=1.
- `o_start`/`o_stop` align with the `o_sda` transition cycle. `o_busy` changes one cycle after the strobe.
- TBUF: `o_busy` falls `BUS_FREE_CLKS`+1 cycles after `o_stop`.
- After reset release with pins held low, `o_scl`/`o_sda` fall `FILT_CLKS`+2 cycles later and strobes fire normally. If SDA falls first while SCL stays high, this is a legitimate START.

## Structure
- Package `i2c_pkg`:
  - default constants `I2C_FILT_CLKS`, `I2C_T_BUF_CLKS`, `I2C_IDLE_TO_CLKS`.
  - busy-FSM state enum `i2c_bus_state_e`.
- Sub-module `i2c_line_filter`: 2-FF sync plus glitch counter, one line, parameters `FILT_CLKS`/`FILT_WIDTH`, outputs the filtered level. Instantiated twice, once per line.
- Edge/START/STOP detection and the busy FSM live in the top module.

## Test plan
- SDA low pulse of 2 clocks while SCL high, pins synchronous to `i_clk` -> no change on `o_sda`, no `o_start`.
- Pulse of 3 clocks -> `o_sda` low 5 clocks after the pin edge, `o_start`=1 for one cycle, `o_busy`=1 the next cycle.
- Address byte 0x50 write followed by STOP -> 9 `o_scl_rise` and 9 `o_scl_fall` strobes, one `o_stop`, `o_busy` low exactly 81 cycles after `o_stop`.
- STOP followed by START 40 cycles later -> `o_busy` never deasserts.
- SCL and SDA driven low on the same `i_clk` edge -> `o_scl_fall` fires, `o_start` does not.
- START, then reset pulsed mid-byte -> all outputs at reset values during reset. After release with pins high, `o_busy`=0 and no strobes.
- START, then both pins held high with no STOP -> `o_busy` drops after 800 cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared constants and types for the I2C bus input conditioner.
//   - I2C_FILT_CLKS    : default glitch-filter length in clocks
//   - I2C_T_BUF_CLKS   : default bus-free time (tBUF) after STOP, in clocks
//   - I2C_IDLE_TO_CLKS : default both-lines-high timeout that releases a
//                        stuck bus, in clocks
//   - i2c_bus_state_e  : states of the bus-busy tracker
package i2c_pkg;

  localparam int I2C_FILT_CLKS    = 3;
  localparam int I2C_T_BUF_CLKS   = 80;
  localparam int I2C_IDLE_TO_CLKS = 800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TBUF = 2'd2
  } i2c_bus_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   One I2C line: 2-FF synchroniser followed by a glitch-rejecting counter.
//   The filtered level only flips after the synced value has disagreed with
//   it for FILT_CLKS consecutive cycles.
// Ports:
//   i_clk          clock
//   i_rstn         asynchronous active-low reset
//   i_pin          raw, asynchronous pad input
//   o_level        filtered level (registered)
//   o_level_next   value o_level takes after the next clock edge; lets the
//                  parent register edge strobes aligned with the level change
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILT_CLKS  = I2C_FILT_CLKS,
  parameter int FILT_WIDTH = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_pin,
  output logic o_level,
  output logic o_level_next
);

  // sync_q[0] is the metastability-catching flop, sync_q[1] the synced value.
  logic [1:0]            sync_q, sync_d;
  logic                  filt_q, filt_d;
  logic [FILT_WIDTH-1:0] cnt_q,  cnt_d;

  always_comb begin
    sync_d = {sync_q[0], i_pin};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == FILT_WIDTH'(FILT_CLKS - 1)) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + FILT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_level      = filt_q;
  assign o_level_next = filt_d;

endmodule

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond
//   Input conditioner for the I2C slave: synchronises and de-glitches SCL/SDA,
//   produces clean levels, single-cycle SCL edge strobes, START/STOP strobes
//   and a bus-busy flag that honours tBUF and a stuck-bus idle timeout.
// Ports:
//   i_clk       clock
//   i_rstn      asynchronous active-low reset
//   i_scl/i_sda raw asynchronous pad inputs
//   o_scl/o_sda filtered levels
//   o_scl_rise  one-cycle strobe, filtered SCL 0->1
//   o_scl_fall  one-cycle strobe, filtered SCL 1->0
//   o_start     one-cycle strobe, START or repeated START
//   o_stop      one-cycle strobe, STOP
//   o_busy      bus owned by some master
module i2c_bus_cond
  import i2c_pkg::*;
#(
  parameter int FILT_CLKS     = I2C_FILT_CLKS,
  parameter int FILT_WIDTH    = 2,
  parameter int BUS_FREE_CLKS = I2C_T_BUF_CLKS,
  parameter int BUS_IDLE_CLKS = I2C_IDLE_TO_CLKS,
  parameter int IDLE_WIDTH    = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_busy
);

  localparam int LINE_SCL = 0;
  localparam int LINE_SDA = 1;

  logic [1:0] pins;
  logic [1:0] lvl;
  logic [1:0] lvl_next;

  assign pins[LINE_SCL] = i_scl;
  assign pins[LINE_SDA] = i_sda;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      i2c_line_filter #(
        .FILT_CLKS  (FILT_CLKS),
        .FILT_WIDTH (FILT_WIDTH)
      ) u_filt (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_pin        (pins[gi]),
        .o_level      (lvl[gi]),
        .o_level_next (lvl_next[gi])
      );
    end
  endgenerate

  logic scl_cur, scl_nxt, sda_cur, sda_nxt;
  assign scl_cur = lvl[LINE_SCL];
  assign scl_nxt = lvl_next[LINE_SCL];
  assign sda_cur = lvl[LINE_SDA];
  assign sda_nxt = lvl_next[LINE_SDA];

  // Strobes are computed from the filter's next level so that, once
  // registered, they line up with the cycle the new level appears.
  // START/STOP need SCL high both before and after the SDA update, which
  // also suppresses them when both lines flip together.
  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_q,    start_d;
  logic stop_q,     stop_d;

  always_comb begin
    scl_rise_d = ~scl_cur & scl_nxt;
    scl_fall_d = scl_cur & ~scl_nxt;
    start_d    = scl_cur & scl_nxt & sda_cur & ~sda_nxt;
    stop_d     = scl_cur & scl_nxt & ~sda_cur & sda_nxt;
  end

  // Busy tracker. One down-counter serves both the tBUF wait and the
  // stuck-bus timeout; it is only meaningful outside IDLE.
  i2c_bus_state_e        state_q, state_d;
  logic [IDLE_WIDTH-1:0] cnt_q,   cnt_d;
  logic                  both_high;
  logic                  cnt_done;

  assign both_high = scl_cur & sda_cur;
  // Leaving on count 1 makes the state change coincide with the counter
  // reaching 0, so o_busy drops BUS_FREE_CLKS+1 cycles after o_stop.
  assign cnt_done  = (cnt_q <= IDLE_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d = ST_BUSY;
          cnt_d   = IDLE_WIDTH'(BUS_IDLE_CLKS);
        end
      end
      ST_BUSY: begin
        if (stop_q) begin
          state_d = ST_TBUF;
          cnt_d   = IDLE_WIDTH'(BUS_FREE_CLKS);
        end else if (!both_high) begin
          cnt_d = IDLE_WIDTH'(BUS_IDLE_CLKS);
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - IDLE_WIDTH'(1);
        end
      end
      ST_TBUF: begin
        if (start_q) begin
          state_d = ST_BUSY;
          cnt_d   = IDLE_WIDTH'(BUS_IDLE_CLKS);
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - IDLE_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_scl      = scl_cur;
  assign o_sda      = sda_cur;
  assign o_scl_rise = scl_rise_q;
  assign o_scl_fall = scl_fall_q;
  assign o_start    = start_q;
  assign o_stop     = stop_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_bus_cond.sv
// tb_i2c_bus_cond
//   Scoreboard bench: stimulus pushes expected (event, cycle) pairs, a
//   monitor on the falling clock edge pops and compares every strobe and
//   every o_busy transition the DUT presents.
module tb_i2c_bus_cond;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_START = 2;
  localparam int K_STOP  = 3;
  localparam int K_BRISE = 4;
  localparam int K_BFALL = 5;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic i_rstn;
  logic i_scl;
  logic i_sda;
  logic o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy;

  int   cyc;
  int   checks;
  int   errors;
  int   n_rise;
  int   n_fall;
  logic prev_busy;
  logic m_scl;
  logic m_sda;
  ev_t  exp_q[$];

  i2c_bus_cond dut (
    .i_clk      (clk),
    .i_rstn     (i_rstn),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_scl      (o_scl),
    .o_sda      (o_sda),
    .o_scl_rise (o_scl_rise),
    .o_scl_fall (o_scl_fall),
    .o_start    (o_start),
    .o_stop     (o_stop),
    .o_busy     (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "scl_rise";
      K_FALL:  return "scl_fall";
      K_START: return "start";
      K_STOP:  return "stop";
      K_BRISE: return "busy_rise";
      default: return "busy_fall";
    endcase
  endfunction

  task automatic push_exp(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_match(input int kind);
    int idx;
    idx = -1;
    checks++;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].cyc == cyc) idx = i;
    end
    if (idx >= 0) begin
      exp_q.delete(idx);
      $display("ev %-9s cyc=%0d ok", kname(kind), cyc);
    end else begin
      errors++;
      $display("FAIL ev_%s: seen at cyc=%0d, required no such event at that cycle",
               kname(kind), cyc);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("chk %s = %0h ok", name, act);
    end
  endtask

  // Monitor: every strobe and busy transition must match a queued expectation.
  initial begin
    prev_busy = 1'b0;
    n_rise    = 0;
    n_fall    = 0;
    forever begin
      @(negedge clk);
      if (!i_rstn) begin
        prev_busy = 1'b0;
      end else begin
        if (o_scl_rise) begin n_rise++; sb_match(K_RISE); end
        if (o_scl_fall) begin n_fall++; sb_match(K_FALL); end
        if (o_start) sb_match(K_START);
        if (o_stop)  sb_match(K_STOP);
        if (o_busy && !prev_busy) sb_match(K_BRISE);
        if (!o_busy && prev_busy) sb_match(K_BFALL);
        prev_busy = o_busy;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive both pins (synchronous to clk) and queue the strobes that the
  // filtered lines must show 2 sync + 3 filter cycles later.
  task automatic drv(input logic scl, input logic sda);
    int te;
    te    = cyc + 5;
    i_scl = scl;
    i_sda = sda;
    if (scl && !m_scl) push_exp(K_RISE, te);
    if (!scl && m_scl) push_exp(K_FALL, te);
    if (scl && m_scl && m_sda && !sda) push_exp(K_START, te);
    if (scl && m_scl && !m_sda && sda) push_exp(K_STOP, te);
    m_scl = scl;
    m_sda = sda;
  endtask

  initial begin
    int t;
    logic [8:0] bits;
    checks = 0;
    errors = 0;
    i_rstn = 1'b0;
    i_scl  = 1'b1;
    i_sda  = 1'b1;
    m_scl  = 1'b1;
    m_sda  = 1'b1;

    // Reset state
    tick(3);
    check("reset_outputs", {25'd0, o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy},
          32'b1100000);
    i_rstn = 1'b1;
    tick(5);

    // 2-clock SDA glitch with SCL high: nothing happens
    t = cyc;
    i_sda = 1'b0;
    tick(2);
    i_sda = 1'b1;
    tick(3);
    @(negedge clk);
    check("glitch_sda_level", {31'd0, o_sda}, 32'd1);
    tick(12);

    // 3-clock pulse: START at +5, STOP 3 later, tBUF afterwards
    t = cyc;
    drv(1'b1, 1'b0);
    push_exp(K_BRISE, t + 6);
    tick(3);
    drv(1'b1, 1'b1);
    push_exp(K_BFALL, t + 3 + 5 + 81);
    tick(1);
    @(negedge clk);
    check("pulse3_sda_at4", {31'd0, o_sda}, 32'd1);
    tick(1);
    @(negedge clk);
    check("pulse3_sda_at5", {31'd0, o_sda}, 32'd0);
    tick(100);

    // Address 0x50 write (byte 0xA0) + ACK, then STOP
    n_rise = 0;
    n_fall = 0;
    t = cyc;
    drv(1'b1, 1'b0);
    push_exp(K_BRISE, t + 6);
    tick(8);
    bits = 9'b1010_0000_0;
    for (int i = 8; i >= 0; i--) begin
      drv(1'b0, m_sda);
      tick(6);
      drv(1'b0, bits[i]);
      tick(6);
      drv(1'b1, bits[i]);
      tick(6);
    end
    t = cyc;
    drv(1'b1, 1'b1);
    push_exp(K_BFALL, t + 5 + 81);
    tick(100);
    check("byte_rise_count", n_rise, 32'd9);
    check("byte_fall_count", n_fall, 32'd9);

    // STOP then START 40 cycles later: busy never drops
    t = cyc;
    drv(1'b1, 1'b0);
    push_exp(K_BRISE, t + 6);
    tick(10);
    drv(1'b1, 1'b1);
    tick(40);
    drv(1'b1, 1'b0);
    tick(10);
    check("busy_held_tbuf", {31'd0, o_busy}, 32'd1);
    t = cyc;
    drv(1'b1, 1'b1);
    push_exp(K_BFALL, t + 5 + 81);
    tick(100);

    // SCL and SDA fall together: scl_fall only, bus stays idle
    drv(1'b0, 1'b0);
    tick(10);
    check("simul_busy", {31'd0, o_busy}, 32'd0);
    drv(1'b1, 1'b1);
    tick(10);

    // START, then reset mid-byte
    t = cyc;
    drv(1'b1, 1'b0);
    push_exp(K_BRISE, t + 6);
    tick(8);
    drv(1'b0, 1'b0);
    tick(11);
    i_rstn = 1'b0;
    #1;
    check("midreset_outputs", {25'd0, o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy},
          32'b1100000);
    i_scl = 1'b1;
    i_sda = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    i_rstn = 1'b1;
    tick(20);
    check("post_reset_busy", {31'd0, o_busy}, 32'd0);

    // START, then both lines high without STOP: idle timeout releases bus
    t = cyc;
    drv(1'b1, 1'b0);
    push_exp(K_BRISE, t + 6);
    tick(8);
    drv(1'b0, 1'b0);
    tick(8);
    drv(1'b0, 1'b1);
    tick(8);
    t = cyc;
    drv(1'b1, 1'b1);
    push_exp(K_BFALL, t + 5 + 800);
    tick(400);
    check("timeout_busy_mid", {31'd0, o_busy}, 32'd1);
    tick(420);

    tick(10);
    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL missing_%s: not seen, required at cyc=%0d", kname(exp_q[i].kind), exp_q[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
